// File: rtl/smpl_capture.sv
// smpl_capture: circular capture buffer for channel_sample bytes.
// Pre-trigger samples fill the ring, a trigger starts the post-trigger
// count, and the finished buffer is played back oldest-first over a
// valid/ready port with one bubble cycle per beat.
module smpl_capture #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic              i_wrt_smpl,
  input  logic [7:0]        i_smpl,
  input  logic              i_trig,
  input  logic [ADDR_W-1:0] i_trig_pos,
  output logic              o_armed,
  output logic              o_cap_done,
  input  logic              i_dump,
  output logic [7:0]        o_rd_data,
  output logic              o_rd_vld,
  input  logic              i_rd_rdy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE,
    S_DUMP
  } state_t;

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_pre_cnt;
  logic [ADDR_W:0]   r_post_cnt;
  logic [ADDR_W:0]   r_beat_cnt;
  logic              r_rd_vld;
  logic [7:0]        r_mem_q;
  logic [7:0]        r_mem [0:DEPTH-1];

  logic [ADDR_W:0]   w_tp;
  logic [ADDR_W:0]   w_pre_thr;
  logic [ADDR_W:0]   w_pre_nxt;
  logic [ADDR_W:0]   w_post_nxt;
  logic              w_clr;
  logic              w_wr_en;
  logic              w_dump_start;
  logic              w_rd_issue;
  logic              w_hs;

  // A post-trigger length of zero is treated as one sample.
  assign w_tp       = (i_trig_pos == '0) ? C_ONE : {1'b0, i_trig_pos};
  assign w_pre_thr  = C_DEPTH - w_tp;
  assign w_pre_nxt  = r_pre_cnt + C_ONE;
  assign w_post_nxt = r_post_cnt + C_ONE;

  assign o_armed    = (r_state == S_ARMED);
  assign o_cap_done = (r_state == S_DONE) || (r_state == S_DUMP);
  assign o_rd_vld   = r_rd_vld;
  // The RAM output register has no reset, so the port reads zero when not valid.
  assign o_rd_data  = r_rd_vld ? r_mem_q : 8'd0;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes; abort (run low) has priority over trig.
  always_comb begin
    w_state_nxt  = r_state;
    w_clr        = 1'b0;
    w_wr_en      = 1'b0;
    w_dump_start = 1'b0;
    w_rd_issue   = 1'b0;
    w_hs         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_clr       = 1'b1;
          w_state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        if (!i_run) begin
          w_state_nxt = S_IDLE;
        end else if (i_wrt_smpl) begin
          w_wr_en = 1'b1;
          if (w_pre_nxt >= w_pre_thr) begin
            w_state_nxt = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (!i_run) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wr_en = i_wrt_smpl;
          if (i_trig) begin
            w_state_nxt = S_POST;
          end
        end
      end
      S_POST: begin
        if (!i_run) begin
          w_state_nxt = S_IDLE;
        end else if (i_wrt_smpl) begin
          w_wr_en = 1'b1;
          if (w_post_nxt >= w_tp) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_dump) begin
          w_dump_start = 1'b1;
          w_state_nxt  = S_DUMP;
        end
      end
      S_DUMP: begin
        if (!r_rd_vld) begin
          w_rd_issue = 1'b1;
        end else if (i_rd_rdy) begin
          w_hs = 1'b1;
          if (r_beat_cnt == C_DEPTH - C_ONE) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Write pointer, capture counters and readout bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_waddr    <= '0;
      r_rd_addr  <= '0;
      r_pre_cnt  <= '0;
      r_post_cnt <= '0;
      r_beat_cnt <= '0;
      r_rd_vld   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_waddr    <= '0;
        r_pre_cnt  <= '0;
        r_post_cnt <= '0;
      end
      if (w_wr_en) begin
        r_waddr <= r_waddr + 1'b1;
        if (r_state == S_PRE) begin
          r_pre_cnt <= w_pre_nxt;
        end
        if (r_state == S_POST) begin
          r_post_cnt <= w_post_nxt;
        end
      end
      if (w_dump_start) begin
        r_rd_addr  <= r_waddr;
        r_beat_cnt <= '0;
        r_rd_vld   <= 1'b0;
      end
      if (w_rd_issue) begin
        r_rd_vld <= 1'b1;
      end
      if (w_hs) begin
        r_rd_vld   <= 1'b0;
        r_rd_addr  <= r_rd_addr + 1'b1;
        r_beat_cnt <= r_beat_cnt + C_ONE;
      end
    end
  end

  // Sample RAM: synchronous write, registered read.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_waddr] <= i_smpl;
    end
    if (w_rd_issue) begin
      r_mem_q <= r_mem[r_rd_addr];
    end
  end

endmodule

// File: tb/tb_smpl_capture.sv
// Directed testbench for smpl_capture.
module tb_smpl_capture;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       wrt_smpl;
  logic [7:0] smpl;
  logic       trig;
  logic [8:0] trig_pos;
  logic       armed;
  logic       cap_done;
  logic       dump;
  logic [7:0] rd_data;
  logic       rd_vld;
  logic       rd_rdy;

  int         n_tests;
  int         n_fail;
  logic [7:0] got [0:511];

  smpl_capture #(.ADDR_W(9), .DEPTH(512)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_run      (run),
    .i_wrt_smpl (wrt_smpl),
    .i_smpl     (smpl),
    .i_trig     (trig),
    .i_trig_pos (trig_pos),
    .o_armed    (armed),
    .o_cap_done (cap_done),
    .i_dump     (dump),
    .o_rd_data  (rd_data),
    .o_rd_vld   (rd_vld),
    .i_rd_rdy   (rd_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] v, input int gap);
    smpl     = v;
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic pulse_dump();
    dump = 1'b1;
    tick();
    dump = 1'b0;
  endtask

  task automatic start_capture(input logic [8:0] tp);
    trig_pos = tp;
    run      = 1'b1;
    tick();
  endtask

  // Drains the readout into got[]; reports beat count, hold violations, timeout.
  task automatic do_dump(input bit rand_rdy, output int nb, output int nunst, output bit tmo);
    logic       stall;
    logic [7:0] held;
    nb    = 0;
    nunst = 0;
    stall = 1'b0;
    held  = 8'd0;
    for (int c = 0; c < 8000; c++) begin
      if (nb >= 512) break;
      if (stall && (!rd_vld || rd_data !== held)) nunst++;
      rd_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      stall  = rd_vld && !rd_rdy;
      held   = rd_data;
      if (rd_vld && rd_rdy) begin
        got[nb] = rd_data;
        nb++;
      end
      tick();
    end
    rd_rdy = 1'b0;
    tmo = (nb < 512);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({armed, cap_done, rd_vld} !== 3'b000 || rd_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: armed/cap_done/rd_vld=%b rd_data=%0d, required 000 and 0",
               {armed, cap_done, rd_vld}, rd_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_write(8'(i), 2);
    n_tests++;
    if ({armed, cap_done, rd_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_hold: armed/cap_done/rd_vld=%b, required 000", {armed, cap_done, rd_vld});
    end
  endtask

  task automatic test_normal();
    int nb, nunst, bad;
    bit tmo;
    start_capture(9'd100);
    for (int i = 0; i < 500; i++) begin
      do_write(8'(i), 4);
      n_tests++;
      if (armed !== (i >= 411)) begin
        n_fail++;
        $display("FAIL normal_armed write %0d: armed=%b, required %b", i, armed, (i >= 411));
      end
    end
    pulse_trig();
    n_tests++;
    if (armed !== 1'b0 || cap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_post: armed=%b cap_done=%b, required 0 0", armed, cap_done);
    end
    for (int i = 500; i < 600; i++) begin
      do_write(8'(i), 4);
      n_tests++;
      if (cap_done !== (i == 599)) begin
        n_fail++;
        $display("FAIL normal_cap_done write %0d: cap_done=%b, required %b", i, cap_done, (i == 599));
      end
    end
    pulse_dump();
    do_dump(1'b0, nb, nunst, tmo);
    n_tests++;
    if (nb != 512 || tmo) begin
      n_fail++;
      $display("FAIL normal_beats: got %0d beats (timeout=%b), required 512", nb, tmo);
    end
    n_tests++;
    if (got[0] !== 8'd88 || got[511] !== 8'd87) begin
      n_fail++;
      $display("FAIL normal_ends: first=%0d last=%0d, required 88 87", got[0], got[511]);
    end
    bad = 0;
    for (int k = 1; k < 512; k++) if (got[k] !== 8'(got[k-1] + 8'd1)) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL normal_order: %0d non-incrementing bytes, required 0", bad);
    end
    n_tests++;
    if (cap_done !== 1'b0 || rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_end: cap_done=%b rd_vld=%b, required 0 0", cap_done, rd_vld);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_trig_pos0_reset_in_dump();
    start_capture(9'd0);
    for (int i = 0; i < 511; i++) begin
      do_write(8'(i), 2);
      if (i >= 509) begin
        n_tests++;
        if (armed !== (i >= 510)) begin
          n_fail++;
          $display("FAIL tp0_armed write %0d: armed=%b, required %b", i, armed, (i >= 510));
        end
      end
    end
    pulse_trig();
    do_write(8'd255, 2);
    n_tests++;
    if (cap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL tp0_done: cap_done=%b after first post write, required 1", cap_done);
    end
    run = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (cap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignores_run: cap_done=%b, required 1", cap_done);
    end
    pulse_dump();
    rd_rdy = 1'b1;
    for (int c = 0; c < 10 && !rd_vld; c++) tick();
    n_tests++;
    if (rd_vld !== 1'b1 || rd_data !== 8'd0) begin
      n_fail++;
      $display("FAIL tp0_first_beat: rd_vld=%b rd_data=%0d, required 1 0", rd_vld, rd_data);
    end
    tick();
    rd_rdy = 1'b0;
    for (int c = 0; c < 10 && !rd_vld; c++) tick();
    repeat (2) tick();
    n_tests++;
    if (rd_vld !== 1'b1 || rd_data !== 8'd1) begin
      n_fail++;
      $display("FAIL tp0_second_beat: rd_vld=%b rd_data=%0d, required 1 1", rd_vld, rd_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({armed, cap_done, rd_vld} !== 3'b000 || rd_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_dump: armed/cap_done/rd_vld=%b rd_data=%0d, required 000 0",
               {armed, cap_done, rd_vld}, rd_data);
    end
    #2 rst_n = 1'b1;
    repeat (4) tick();
    n_tests++;
    if ({armed, cap_done, rd_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL after_reset_idle: armed/cap_done/rd_vld=%b, required 000", {armed, cap_done, rd_vld});
    end
  endtask

  task automatic test_backpressure();
    int nb, nunst, bad;
    bit tmo;
    start_capture(9'd511);
    n_tests++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL tp511_pre: armed=%b before any write, required 0", armed);
    end
    do_write(8'd0, 2);
    n_tests++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL tp511_armed: armed=%b after 1 write, required 1", armed);
    end
    pulse_trig();
    for (int i = 1; i < 512; i++) begin
      do_write(8'(i), 2);
      if (i >= 510) begin
        n_tests++;
        if (cap_done !== (i == 511)) begin
          n_fail++;
          $display("FAIL tp511_done write %0d: cap_done=%b, required %b", i, cap_done, (i == 511));
        end
      end
    end
    pulse_dump();
    do_dump(1'b1, nb, nunst, tmo);
    n_tests++;
    if (nb != 512 || tmo) begin
      n_fail++;
      $display("FAIL bp_beats: got %0d beats (timeout=%b), required 512", nb, tmo);
    end
    n_tests++;
    if (nunst != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d hold violations, required 0", nunst);
    end
    bad = 0;
    for (int k = 0; k < 512; k++) if (got[k] !== 8'(k)) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_order: %0d bytes out of place (first=%0d), required 0", bad, got[0]);
    end
    n_tests++;
    if (cap_done !== 1'b0 || rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end: cap_done=%b rd_vld=%b, required 0 0", cap_done, rd_vld);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_early_trig();
    int nb, nunst;
    bit tmo;
    start_capture(9'd100);
    for (int i = 0; i <= 10; i++) do_write(8'(i), 1);
    pulse_trig();
    for (int i = 11; i <= 420; i++) begin
      do_write(8'(i), 1);
      if (i == 11 || i == 410 || i == 411) begin
        n_tests++;
        if (armed !== (i >= 411)) begin
          n_fail++;
          $display("FAIL early_armed write %0d: armed=%b, required %b", i, armed, (i >= 411));
        end
      end
    end
    pulse_trig();
    for (int i = 421; i <= 520; i++) do_write(8'(i), 1);
    n_tests++;
    if (cap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL early_done: cap_done=%b, required 1", cap_done);
    end
    pulse_dump();
    do_dump(1'b0, nb, nunst, tmo);
    n_tests++;
    if (nb != 512 || got[0] !== 8'd9 || got[511] !== 8'd8) begin
      n_fail++;
      $display("FAIL early_dump: beats=%0d first=%0d last=%0d, required 512 9 8", nb, got[0], got[511]);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    start_capture(9'd100);
    for (int i = 0; i < 412; i++) do_write(8'(i), 1);
    pulse_dump();
    tick();
    n_tests++;
    if (armed !== 1'b1 || cap_done !== 1'b0 || rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_in_armed: armed=%b cap_done=%b rd_vld=%b, required 1 0 0", armed, cap_done, rd_vld);
    end
    pulse_trig();
    for (int i = 0; i < 5; i++) do_write(8'(i), 1);
    run = 1'b0;
    tick();
    n_tests++;
    if (armed !== 1'b0 || cap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_post: armed=%b cap_done=%b, required 0 0", armed, cap_done);
    end
    start_capture(9'd100);
    for (int i = 0; i < 412; i++) begin
      do_write(8'(i), 1);
      if (i >= 410) begin
        n_tests++;
        if (armed !== (i == 411)) begin
          n_fail++;
          $display("FAIL restart_armed write %0d: armed=%b, required %b", i, armed, (i == 411));
        end
      end
    end
    trig     = 1'b1;
    run      = 1'b0;
    trig_pos = 9'd511;
    tick();
    trig = 1'b0;
    run  = 1'b1;
    tick();
    do_write(8'd0, 1);
    n_tests++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL trig_with_abort: armed=%b after restart write, required 1", armed);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_post();
    start_capture(9'd100);
    for (int i = 0; i < 412; i++) do_write(8'(i), 1);
    pulse_trig();
    for (int i = 0; i < 3; i++) do_write(8'(i), 1);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({armed, cap_done, rd_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_post: armed/cap_done/rd_vld=%b, required 000", {armed, cap_done, rd_vld});
    end
    run = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) tick();
    start_capture(9'd511);
    do_write(8'd0, 1);
    n_tests++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_restart: armed=%b, required 1", armed);
    end
    run = 1'b0;
    tick();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    wrt_smpl = 1'b0;
    smpl     = 8'd0;
    trig     = 1'b0;
    trig_pos = 9'd0;
    dump     = 1'b0;
    rd_rdy   = 1'b0;
    test_reset();
    test_normal();
    test_trig_pos0_reset_in_dump();
    test_backpressure();
    test_early_trig();
    test_abort();
    test_reset_mid_post();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/smpl_capture.md
Name: smpl_capture

Overview:
- Consumer end of the channel_sample → RAM sample interface.
- Accepts the packed 8-bit `smpl` bytes qualified by `wrt_smpl` into a circular capture buffer around a trigger event.
- Once capture completes, plays the buffer back oldest-first over a valid/ready read port for the host/UART path.
- Sits in the 100 MHz `clk` domain beside channel_sample and the trigger logic.

Parameters:
- ADDR_W, 9, buffer address width.
- DEPTH, 512, buffer entries; always 2**ADDR_W.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; high = capture enabled, low = abort to IDLE.
- wrt_smpl  in  1  one-cycle strobe; `smpl` valid this cycle.
- smpl  in  8  packed sample byte from channel_sample.
- trig  in  1  one-cycle trigger pulse from trigger logic.
- trig_pos  in  ADDR_W  number of post-trigger samples; 0 is treated as 1.
- armed  out  1  high in ARMED state.
- cap_done  out  1  high in DONE and DUMP states.
- dump  in  1  one-cycle pulse; starts readout when in DONE.
- rd_data  out  8  readout byte.
- rd_vld  out  1  rd_data valid.
- rd_rdy  in  1  consumer accepts rd_data.

Behaviour:
- Reset:
  - state = IDLE; all counters and addresses = 0.
  - armed, cap_done, rd_vld = 0; rd_data = 0.
  - Buffer contents are don't-care.
- Buffer:
  - DEPTH x 8 array with synchronous read.
  - waddr increments by 1 on every accepted write, wrapping at DEPTH-1 → 0.
- States:
  - IDLE:
    - run=1 → PRE; clear waddr, pre_cnt, post_cnt.
  - PRE:
    - Each wrt_smpl writes smpl at waddr and increments pre_cnt.
    - When pre_cnt reaches DEPTH - trig_pos → ARMED.
    - trig is ignored in PRE.
  - ARMED:
    - wrt_smpl keeps writing and wrapping.
    - trig=1 → POST.
    - A sample written in the same cycle as trig is a pre-trigger sample.
  - POST:
    - Each wrt_smpl writes and increments post_cnt.
    - On the write that makes post_cnt == trig_pos → DONE, same cycle.
    - Further trig pulses are ignored.
  - DONE:
    - No writes; wrt_smpl is ignored.
    - dump=1 → DUMP; rd_addr = waddr, which is the oldest entry.
  - DUMP:
    - Issue a read at rd_addr; the next cycle rd_data is registered and rd_vld=1.
    - Hold rd_data/rd_vld stable until rd_rdy=1.
    - On rd_vld & rd_rdy: rd_vld=0 the next cycle, rd_addr increments with wrap, beat count increments.
    - This gives one bubble cycle per beat, i.e. at most one beat per 2 clk.
    - After DEPTH beats → IDLE; cap_done drops the cycle after the last handshake.
- Abort:
  - run=0 in PRE, ARMED or POST → IDLE next cycle; cap_done stays 0.
  - run has no effect in DONE or DUMP; readout completes regardless.
  - In IDLE after a completed dump, run still high → re-enter PRE immediately for the next capture.
- Simultaneous events:
  - wrt_smpl with the PRE→ARMED transition: the write is counted in PRE.
  - trig with abort: abort wins.
  - dump outside DONE: ignored.
- Reset mid-operation: immediate return to reset values; no partial readout continues.
- Counters are ADDR_W+1 bits wide so that DEPTH is representable; no overflow.

Test Plan:
- Reset/idle: assert rst_n=0 mid-POST → armed=0, cap_done=0, rd_vld=0 the same cycle; after release with run=0, state stays IDLE.
- Normal capture (trig_pos=100):
  - Stimulus: smpl = write index mod 256, wrt_smpl every 4 clk; trig after write 499; 100 further writes; then dump with rd_rdy=1.
  - Required: armed rises after write 411; cap_done rises on write 599; 512 bytes read; first byte = 88, last byte = 599 mod 256 = 87, strictly incrementing mod 256.
- Early trigger (trig_pos=100): trig pulse after write 10 → ignored; armed stays 0 until pre_cnt = 412; a later trig completes capture normally.
- Boundary trig_pos:
  - trig_pos=0 → behaves as 1; capture ends on the first post-trigger write.
  - trig_pos=511 → armed after 1 write.
- Backpressure: random rd_rdy during DUMP → every byte delivered exactly once, in order; rd_data stable while rd_vld=1 and rd_rdy=0; exactly 512 handshakes; then IDLE.
- Abort/simultaneous:
  - run=0 in POST → IDLE, cap_done=0; the next run restarts with pre_cnt=0.
  - trig coinciding with run=0 → IDLE.
  - dump pulsed in ARMED → ignored.
